rob_commit: RTL and testbench

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rob_commit.sv | 113 +++++++++++
 tb/tb_rob_commit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Reorder buffer commit stage: circular entry array, out-of-order completion,
// in-order single-wide commit with registered free-register / flag strobes.
package rob_pkg;
  localparam int NUM_FU       = 4;
  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_FLAGS    = 4;
endpackage

module rob_commit
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = 16
) (
  input  logic                                               clk_i,
  input  logic                                               reset_i,
  input  logic                                               flush_i,
  input  logic                                               alloc_v_i,
  output logic                                               alloc_ready_o,
  output logic [$clog2(ROB_DEPTH)-1:0]                       alloc_tag_o,
  input  logic                                               alloc_dest_v_i,
  input  logic [$clog2(NUM_PHYS_REG)-1:0]                    alloc_old_phys_i,
  input  logic                                               alloc_flag_v_i,
  input  logic [NUM_FU-1:0]                                  exe_done_v_i,
  input  logic [NUM_FU-1:0][$clog2(ROB_DEPTH)-1:0]           exe_tag_i,
  input  logic [NUM_FU-1:0][NUM_FLAGS*2-1:0]                 exe_flag_i,
  output logic                                               rob_phys_valid_o,
  output logic [$clog2(NUM_PHYS_REG)-1:0]                    rob_phys_reg_cl_o,
  output logic                                               rob_flag_valid_o,
  output logic [NUM_FLAGS*2-1:0]                             rob_flag_o,
  output logic [$clog2(ROB_DEPTH):0]                         count_o
);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int PW = $clog2(NUM_PHYS_REG);
  localparam int FW = NUM_FLAGS * 2;
  localparam logic [TW:0] FULL_CNT = (TW+1)'(ROB_DEPTH);

  typedef struct packed {
    logic          valid;
    logic          done;
    logic          dest_v;
    logic [PW-1:0] old_phys;
    logic          flag_v;
    logic [FW-1:0] flag;
  } rob_entry_t;

  rob_entry_t [ROB_DEPTH-1:0]         rob_q;
  logic [TW-1:0]                      head_q, tail_q;
  logic [TW:0]                        count_q;
  logic [ROB_DEPTH-1:0]               hit;
  logic [ROB_DEPTH-1:0][FW-1:0]       hit_flag;
  logic                               alloc_fire, commit_fire;
  rob_entry_t                         head_e;

  assign alloc_ready_o = (count_q != FULL_CNT);
  assign alloc_tag_o   = tail_q;
  assign count_o       = count_q;
  assign head_e        = rob_q[head_q];
  assign alloc_fire    = alloc_v_i & alloc_ready_o & ~flush_i;
  assign commit_fire   = head_e.valid & head_e.done & ~flush_i;

  // Later FUs overwrite earlier ones, so the highest index wins on a shared tag.
  always_comb begin
    hit      = '0;
    hit_flag = '0;
    for (int e = 0; e < ROB_DEPTH; e++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (exe_done_v_i[i] && exe_tag_i[i] == TW'(e)) begin
          hit[e]      = 1'b1;
          hit_flag[e] = exe_flag_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rob_q             <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      rob_phys_valid_o  <= 1'b0;
      rob_phys_reg_cl_o <= '0;
      rob_flag_valid_o  <= 1'b0;
      rob_flag_o        <= '0;
    end else begin
      for (int e = 0; e < ROB_DEPTH; e++) begin
        if (rob_q[e].valid && hit[e]) begin
          rob_q[e].done <= 1'b1;
          rob_q[e].flag <= hit_flag[e];
        end
      end
      // Commit clears the head before allocation; they only alias when full,
      // and then allocation is already blocked.
      if (commit_fire) begin
        rob_q[head_q].valid <= 1'b0;
        rob_q[head_q].done  <= 1'b0;
        head_q              <= head_q + TW'(1);
      end
      if (alloc_fire) begin
        rob_q[tail_q] <= '{valid: 1'b1, done: 1'b0, dest_v: alloc_dest_v_i,
                           old_phys: alloc_old_phys_i, flag_v: alloc_flag_v_i,
                           flag: '0};
        tail_q        <= tail_q + TW'(1);
      end
      count_q <= count_q + (TW+1)'(alloc_fire) - (TW+1)'(commit_fire);

      rob_phys_valid_o  <= commit_fire & head_e.dest_v;
      rob_phys_reg_cl_o <= commit_fire ? head_e.old_phys : '0;
      rob_flag_valid_o  <= commit_fire & head_e.flag_v;
      rob_flag_o        <= commit_fire ? head_e.flag : '0;
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: latency, ordering, full/wrap, flag merge,
// flush and reset behaviour with hand-computed expectations.
module tb_rob_commit;
  import rob_pkg::*;
  localparam int D  = 16;
  localparam int TW = $clog2(D);
  localparam int PW = $clog2(NUM_PHYS_REG);
  localparam int FW = NUM_FLAGS * 2;

  logic                      clk_i = 1'b0;
  logic                      reset_i, flush_i, alloc_v_i, alloc_ready_o;
  logic [TW-1:0]             alloc_tag_o;
  logic                      alloc_dest_v_i, alloc_flag_v_i;
  logic [PW-1:0]             alloc_old_phys_i;
  logic [NUM_FU-1:0]         exe_done_v_i;
  logic [NUM_FU-1:0][TW-1:0] exe_tag_i;
  logic [NUM_FU-1:0][FW-1:0] exe_flag_i;
  logic                      rob_phys_valid_o, rob_flag_valid_o;
  logic [PW-1:0]             rob_phys_reg_cl_o;
  logic [FW-1:0]             rob_flag_o;
  logic [TW:0]               count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  rob_commit #(.ROB_DEPTH(D)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .alloc_dest_v_i(alloc_dest_v_i), .alloc_old_phys_i(alloc_old_phys_i),
    .alloc_flag_v_i(alloc_flag_v_i), .exe_done_v_i(exe_done_v_i),
    .exe_tag_i(exe_tag_i), .exe_flag_i(exe_flag_i),
    .rob_phys_valid_o(rob_phys_valid_o), .rob_phys_reg_cl_o(rob_phys_reg_cl_o),
    .rob_flag_valid_o(rob_flag_valid_o), .rob_flag_o(rob_flag_o), .count_o(count_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_exe();
    exe_done_v_i = '0;
    exe_tag_i    = '0;
    exe_flag_i   = '0;
  endtask

  task automatic set_exe(input int fu, input logic [TW-1:0] tag, input logic [FW-1:0] fl);
    exe_done_v_i[fu] = 1'b1;
    exe_tag_i[fu]    = tag;
    exe_flag_i[fu]   = fl;
  endtask

  task automatic alloc(input logic dv, input logic [PW-1:0] op, input logic fv);
    alloc_v_i = 1'b1; alloc_dest_v_i = dv; alloc_old_phys_i = op; alloc_flag_v_i = fv;
    tick();
    alloc_v_i = 1'b0; alloc_dest_v_i = 1'b0; alloc_old_phys_i = '0; alloc_flag_v_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    flush_i = 1'b0; alloc_v_i = 1'b0; alloc_dest_v_i = 1'b0; alloc_flag_v_i = 1'b0;
    alloc_old_phys_i = '0; clear_exe();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    checks++; if (alloc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", alloc_ready_o); end
    checks++; if (alloc_tag_o !== 4'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", alloc_tag_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if ({rob_phys_valid_o, rob_flag_valid_o, rob_phys_reg_cl_o, rob_flag_o} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%b%b %h %h exp=0", rob_phys_valid_o, rob_flag_valid_o, rob_phys_reg_cl_o, rob_flag_o); end
  endtask

  task automatic test_single();
    do_reset();
    checks++; if (alloc_tag_o !== 4'd0) begin errors++; $display("FAIL single_tag got=%0d exp=0", alloc_tag_o); end
    alloc(1'b1, 6'h23, 1'b0);
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count_o); end
    set_exe(0, 4'd0, 8'h00);
    tick(); clear_exe();
    checks++; if (rob_phys_valid_o !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", rob_phys_valid_o); end
    tick();
    checks++; if (rob_phys_valid_o !== 1'b1 || rob_phys_reg_cl_o !== 6'h23) begin
      errors++; $display("FAIL single_commit got=%b/%h exp=1/23", rob_phys_valid_o, rob_phys_reg_cl_o); end
    checks++; if (rob_flag_valid_o !== 1'b0) begin errors++; $display("FAIL single_flagv got=%b exp=0", rob_flag_valid_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL single_count0 got=%0d exp=0", count_o); end
    tick();
    checks++; if (rob_phys_valid_o !== 1'b0 || rob_phys_reg_cl_o !== 6'h00) begin
      errors++; $display("FAIL single_oneshot got=%b/%h exp=0/00", rob_phys_valid_o, rob_phys_reg_cl_o); end
  endtask

  task automatic test_out_of_order();
    logic [PW-1:0] exp_reg;
    do_reset();
    alloc(1'b1, 6'd10, 1'b0);
    alloc(1'b1, 6'd11, 1'b0);
    alloc(1'b1, 6'd12, 1'b0);
    set_exe(0, 4'd2, 8'h00); tick(); clear_exe();
    set_exe(1, 4'd1, 8'h00); tick(); clear_exe();
    checks++; if (rob_phys_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_hold got=%b exp=0", rob_phys_valid_o); end
    set_exe(2, 4'd0, 8'h00); tick(); clear_exe();
    checks++; if (rob_phys_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_latency got=%b exp=0", rob_phys_valid_o); end
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_reg = PW'(10 + k);
      checks++; if (rob_phys_valid_o !== 1'b1 || rob_phys_reg_cl_o !== exp_reg) begin
        errors++; $display("FAIL ooo_order%0d got=%b/%0d exp=1/%0d", k, rob_phys_valid_o, rob_phys_reg_cl_o, exp_reg); end
    end
    tick();
    checks++; if (rob_phys_valid_o !== 1'b0 || count_o !== 5'd0) begin
      errors++; $display("FAIL ooo_drain got=%b/%0d exp=0/0", rob_phys_valid_o, count_o); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int k = 0; k < D; k++) alloc(1'b1, PW'(k), 1'b0);
    checks++; if (alloc_ready_o !== 1'b0 || count_o !== 5'd16) begin
      errors++; $display("FAIL full_state got=%b/%0d exp=0/16", alloc_ready_o, count_o); end
    set_exe(0, 4'd0, 8'h00);
    alloc_v_i = 1'b1; alloc_dest_v_i = 1'b1; alloc_old_phys_i = 6'h30;
    tick(); clear_exe();
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL full_reject0 got=%0d exp=16", count_o); end
    tick();
    checks++; if (count_o !== 5'd15) begin errors++; $display("FAIL full_commit_cycle got=%0d exp=15", count_o); end
    checks++; if (rob_phys_valid_o !== 1'b1 || rob_phys_reg_cl_o !== 6'd0) begin
      errors++; $display("FAIL full_commit_out got=%b/%0d exp=1/0", rob_phys_valid_o, rob_phys_reg_cl_o); end
    checks++; if (alloc_ready_o !== 1'b1 || alloc_tag_o !== 4'd0) begin
      errors++; $display("FAIL full_wrap_tag got=%b/%0d exp=1/0", alloc_ready_o, alloc_tag_o); end
    tick();
    alloc_v_i = 1'b0; alloc_dest_v_i = 1'b0; alloc_old_phys_i = '0;
    checks++; if (count_o !== 5'd16 || alloc_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_refill got=%0d/%b exp=16/0", count_o, alloc_ready_o); end
    checks++; if (alloc_tag_o !== 4'd1) begin errors++; $display("FAIL full_tail got=%0d exp=1", alloc_tag_o); end
  endtask

  task automatic test_flag_merge();
    bit seen = 0;
    do_reset();
    alloc(1'b0, 6'd0, 1'b0);
    alloc(1'b0, 6'd0, 1'b0);
    alloc(1'b0, 6'd0, 1'b0);
    alloc(1'b0, 6'd0, 1'b1);
    set_exe(0, 4'd0, 8'h00);
    set_exe(3, 4'd1, 8'h00);
    set_exe(1, 4'd3, 8'h0F);
    set_exe(2, 4'd3, 8'hA5);
    tick(); clear_exe();
    set_exe(0, 4'd2, 8'h00);
    tick(); clear_exe();
    for (int k = 0; k < 10 && !seen; k++) begin
      if (rob_flag_valid_o === 1'b1) begin
        seen = 1;
        checks++; if (rob_flag_o !== 8'hA5) begin errors++; $display("FAIL flag_merge got=%h exp=a5", rob_flag_o); end
      end else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL flag_timeout got=none exp=strobe"); end
    tick();
    checks++; if (rob_flag_valid_o !== 1'b0 || rob_flag_o !== 8'h00 || count_o !== 5'd0) begin
      errors++; $display("FAIL flag_idle got=%b/%h/%0d exp=0/00/0", rob_flag_valid_o, rob_flag_o, count_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 5; k++) alloc(1'b1, PW'(k + 1), 1'b1);
    set_exe(0, 4'd0, 8'h11);
    set_exe(1, 4'd1, 8'h22);
    tick(); clear_exe();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++; if (rob_phys_valid_o !== 1'b0 || rob_flag_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_strobe got=%b/%b exp=0/0", rob_phys_valid_o, rob_flag_valid_o); end
    checks++; if (count_o !== 5'd0 || alloc_tag_o !== 4'd0) begin
      errors++; $display("FAIL flush_state got=%0d/%0d exp=0/0", count_o, alloc_tag_o); end
    tick();
    checks++; if (rob_phys_valid_o !== 1'b0) begin errors++; $display("FAIL flush_late got=%b exp=0", rob_phys_valid_o); end
    alloc(1'b1, 6'h3F, 1'b0);
    checks++; if (count_o !== 5'd1 || alloc_tag_o !== 4'd1) begin
      errors++; $display("FAIL flush_realloc got=%0d/%0d exp=1/1", count_o, alloc_tag_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc(1'b1, 6'h05, 1'b0);
    set_exe(3, 4'd0, 8'h00);
    tick(); clear_exe();
    alloc(1'b1, 6'h06, 1'b0);
    checks++; if (count_o !== 5'd1 || alloc_tag_o !== 4'd2) begin
      errors++; $display("FAIL b2b_count got=%0d/%0d exp=1/2", count_o, alloc_tag_o); end
    checks++; if (rob_phys_valid_o !== 1'b1 || rob_phys_reg_cl_o !== 6'h05) begin
      errors++; $display("FAIL b2b_commit got=%b/%h exp=1/05", rob_phys_valid_o, rob_phys_reg_cl_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 8; k++) alloc(1'b1, PW'(k + 40), 1'b1);
    set_exe(0, 4'd0, 8'h33);
    tick(); clear_exe();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++; if (rob_phys_valid_o !== 1'b0 || rob_flag_valid_o !== 1'b0 || rob_phys_reg_cl_o !== 6'd0 || rob_flag_o !== 8'd0) begin
      errors++; $display("FAIL rstmid_out got=%b/%b/%h/%h exp=0", rob_phys_valid_o, rob_flag_valid_o, rob_phys_reg_cl_o, rob_flag_o); end
    checks++; if (alloc_ready_o !== 1'b1 || count_o !== 5'd0 || alloc_tag_o !== 4'd0) begin
      errors++; $display("FAIL rstmid_state got=%b/%0d/%0d exp=1/0/0", alloc_ready_o, count_o, alloc_tag_o); end
    tick();
    checks++; if (rob_phys_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_late got=%b exp=0", rob_phys_valid_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_full_wrap();
    test_flag_merge();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
